// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential two-digit BCD to 6-bit binary converter.
// Used to write time-set digits from the BCD display side back into the
// binary hour/minute/second counters. The tens digit is multiplied by ten as
// (msb << 3) + (msb << 1) over two cycles, then the units digit is added.
// Valid/ready handshakes on both the input and output sides.
// Optional build macro: BCD_TO_BIN_SATURATE_EN. When defined, a range
// overflow with legal digits reports MAX_VAL instead of 0.
module bcd_to_bin #(
  parameter int unsigned MAX_VAL = 59
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_clear,
  input  logic [3:0] i_bcd_msb,
  input  logic [3:0] i_bcd_lsb,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [5:0] o_bin,
  output logic       o_err,
  output logic       o_valid,
  input  logic       i_ready
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL8,
    ST_MUL2,
    ST_ADD,
    ST_DONE
  } state_t;

  localparam logic [7:0] LP_MAX_ACC = 8'(MAX_VAL);
  localparam logic [5:0] LP_MAX_BIN = 6'(MAX_VAL);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_msb;
  logic [3:0] r_lsb;
  logic       r_digit_err;
  logic [7:0] r_acc;
  logic [5:0] r_bin;
  logic       r_err;

  logic       w_accept;
  logic [7:0] w_sum;
  logic       w_range_err;
  logic [5:0] w_bin_next;
  logic       w_err_next;

  // Handshake flags come straight from the state so they never lag it.
  assign o_ready = (r_state == ST_IDLE);
  assign o_valid = (r_state == ST_DONE);
  assign o_bin   = r_bin;
  assign o_err   = r_err;

  // A clear in the same cycle as an offered input wins, so nothing is captured.
  assign w_accept    = i_valid && o_ready && !i_clear;
  assign w_sum       = r_acc + {4'd0, r_lsb};
  assign w_range_err = (w_sum > LP_MAX_ACC);

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state sequencing; fixed four-cycle path regardless of digit legality.
  always_comb begin
    w_state_next = r_state;
    if (i_clear) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (i_valid) w_state_next = ST_MUL8;
        ST_MUL8: w_state_next = ST_MUL2;
        ST_MUL2: w_state_next = ST_ADD;
        ST_ADD:  w_state_next = ST_DONE;
        ST_DONE: if (i_ready) w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Result formatting: illegal digits always report 0, range overflow is build-dependent.
  always_comb begin
    w_err_next = r_digit_err || w_range_err;
    w_bin_next = w_sum[5:0];
`ifdef BCD_TO_BIN_SATURATE_EN
    if (r_digit_err) begin
      w_bin_next = 6'd0;
    end else if (w_range_err) begin
      w_bin_next = LP_MAX_BIN;
    end
`else
    if (w_err_next) begin
      w_bin_next = 6'd0;
    end
`endif
  end

  // Datapath: digit capture, shift-add accumulation and the held output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_msb       <= 4'd0;
      r_lsb       <= 4'd0;
      r_digit_err <= 1'b0;
      r_acc       <= 8'd0;
      r_bin       <= 6'd0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_msb       <= i_bcd_msb;
            r_lsb       <= i_bcd_lsb;
            r_digit_err <= (i_bcd_msb > 4'd9) || (i_bcd_lsb > 4'd9);
          end
        end
        ST_MUL8: r_acc <= {1'b0, r_msb, 3'b000};
        ST_MUL2: r_acc <= r_acc + {3'b000, r_msb, 1'b0};
        ST_ADD: begin
          if (!i_clear) begin
            r_acc <= w_sum;
            r_bin <= w_bin_next;
            r_err <= w_err_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: scoreboard bench for the BCD to binary converter.
// Expected results come from a plain arithmetic model (tens*10 + units) and
// are queued at the input handshake; a negedge monitor compares them against
// the DUT whenever it presents a result, including the fixed latency.
module tb_bcd_to_bin;

  localparam int MAXV = 59;

  typedef struct {
    logic [5:0] bin;
    logic       err;
    int         hs;
  } exp_t;

  logic       i_clk     = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_clear   = 1'b0;
  logic [3:0] i_bcd_msb = 4'd0;
  logic [3:0] i_bcd_lsb = 4'd0;
  logic       i_valid   = 1'b0;
  logic       i_ready   = 1'b0;
  logic       o_ready;
  logic [5:0] o_bin;
  logic       o_err;
  logic       o_valid;

  exp_t       sbQ[$];
  int         checks     = 0;
  int         errors     = 0;
  int         cycleCount = 0;
  bit         frontSeen  = 1'b0;
  logic [5:0] lastBin    = 6'd0;
  logic       lastErr    = 1'b0;

  bcd_to_bin #(.MAX_VAL(MAXV)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (i_clear),
    .i_bcd_msb (i_bcd_msb),
    .i_bcd_lsb (i_bcd_lsb),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_bin     (o_bin),
    .o_err     (o_err),
    .o_valid   (o_valid),
    .i_ready   (i_ready)
  );

  // Free-running clock and cycle counter used for latency checks.
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  // Reference model: decimal value of the two digits, then the error rules.
  function automatic void refModel(input int m, input int l, output logic [5:0] bin, output logic err);
    int v;
    v = m * 10 + l;
    if (m > 9 || l > 9) begin
      bin = 6'd0;
      err = 1'b1;
    end else if (v > MAXV) begin
      err = 1'b1;
`ifdef BCD_TO_BIN_SATURATE_EN
      bin = 6'(MAXV);
`else
      bin = 6'd0;
`endif
    end else begin
      bin = 6'(v);
      err = 1'b0;
    end
  endfunction

  // Called at posedge+1; waits for o_ready, offers one input for one cycle.
  task automatic applyStimulus(input logic [3:0] m, input logic [3:0] l, input bit randReady, input bit expectResult);
    exp_t e;
    int   waited;
    waited = 0;
    while (o_ready !== 1'b1 && waited < 100) begin
      @(posedge i_clk); #1;
      if (randReady) i_ready = 1'($urandom_range(0, 1));
      waited++;
    end
    if (o_ready !== 1'b1) begin
      checkOutput("ready_timeout", 32'(o_ready), 32'd1);
      return;
    end
    i_bcd_msb = m;
    i_bcd_lsb = l;
    i_valid   = 1'b1;
    if (expectResult) begin
      refModel(int'(m), int'(l), e.bin, e.err);
      e.hs = cycleCount + 1;
      sbQ.push_back(e);
      lastBin = e.bin;
      lastErr = e.err;
    end
    @(posedge i_clk); #1;
    i_valid   = 1'b0;
    i_bcd_msb = 4'($urandom_range(0, 15));
    i_bcd_lsb = 4'($urandom_range(0, 15));
    if (randReady) i_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    i_ready = 1'b1;
    while (sbQ.size() != 0 && n < 200) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (sbQ.size() != 0) checkOutput("drain_timeout", 32'(sbQ.size()), 32'd0);
  endtask

  // Monitor: compares every presented result against the queue head.
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_valid === 1'b1) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_valid", 32'(o_valid), 32'd0);
        end else begin
          if (!frontSeen) begin
            checkOutput("latency", 32'(cycleCount), 32'(sbQ[0].hs + 3));
            frontSeen = 1'b1;
          end
          checkOutput("o_bin", 32'(o_bin), 32'(sbQ[0].bin));
          checkOutput("o_err", 32'(o_err), 32'(sbQ[0].err));
          if (i_ready === 1'b1) begin
            void'(sbQ.pop_front());
            frontSeen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [3:0] m;
    logic [3:0] l;

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;
    checkOutput("reset_ready", 32'(o_ready), 32'd1);
    checkOutput("reset_valid", 32'(o_valid), 32'd0);
    checkOutput("reset_bin",   32'(o_bin),   32'd0);
    checkOutput("reset_err",   32'(o_err),   32'd0);

    $display("[TB] basic conversion 4,2");
    i_ready = 1'b1;
    applyStimulus(4'd4, 4'd2, 1'b0, 1'b1);
    waitDrain();
    checkOutput("ready_after_done", 32'(o_ready), 32'd1);
    checkOutput("valid_after_done", 32'(o_valid), 32'd0);

    $display("[TB] boundary and error digits");
    applyStimulus(4'd5, 4'd9,  1'b0, 1'b1);
    waitDrain();
    applyStimulus(4'd6, 4'd0,  1'b0, 1'b1);
    waitDrain();
    applyStimulus(4'd3, 4'd12, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(4'd15, 4'd15, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] output backpressure with result 17");
    i_ready = 1'b0;
    applyStimulus(4'd1, 4'd7, 1'b0, 1'b1);
    n = 0;
    while (o_valid !== 1'b1 && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    checkOutput("hold_valid_arrived", 32'(o_valid), 32'd1);
    repeat (10) begin
      i_valid   = 1'b1;
      i_bcd_msb = 4'd8;
      i_bcd_lsb = 4'd8;
      @(posedge i_clk); #1;
      checkOutput("hold_ready_low", 32'(o_ready), 32'd0);
      checkOutput("hold_valid",     32'(o_valid), 32'd1);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    checkOutput("valid_drop", 32'(o_valid), 32'd0);
    checkOutput("ready_back", 32'(o_ready), 32'd1);
    repeat (8) @(posedge i_clk);
    #1;

    $display("[TB] clear during MUL2");
    i_bcd_msb = 4'd2;
    i_bcd_lsb = 4'd5;
    i_valid   = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    i_clear = 1'b1;
    @(posedge i_clk); #1;
    i_clear = 1'b0;
    checkOutput("clr_ready", 32'(o_ready), 32'd1);
    checkOutput("clr_valid", 32'(o_valid), 32'd0);
    checkOutput("clr_bin",   32'(o_bin),   32'(lastBin));
    checkOutput("clr_err",   32'(o_err),   32'(lastErr));
    repeat (6) @(posedge i_clk);
    #1;

    $display("[TB] clear together with valid in IDLE");
    i_bcd_msb = 4'd3;
    i_bcd_lsb = 4'd3;
    i_valid   = 1'b1;
    i_clear   = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_clear = 1'b0;
    checkOutput("clr_nocapture", 32'(o_ready), 32'd1);
    repeat (6) @(posedge i_clk);
    #1;

    $display("[TB] reset during ADD");
    i_bcd_msb = 4'd4;
    i_bcd_lsb = 4'd4;
    i_valid   = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    #1;
    i_reset_n = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(o_ready), 32'd1);
    checkOutput("rst_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_bin",   32'(o_bin),   32'd0);
    checkOutput("rst_err",   32'(o_err),   32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    lastBin   = 6'd0;
    lastErr   = 1'b0;
    @(posedge i_clk); #1;
    applyStimulus(4'd2, 4'd3, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] randomized conversions");
    repeat (40) begin
      m = 4'($urandom_range(0, 9));
      l = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) m = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) l = 4'($urandom_range(10, 15));
      applyStimulus(m, l, 1'b1, 1'b1);
    end
    waitDrain();
    repeat (6) @(posedge i_clk);
    #1;
    checkOutput("queue_empty", 32'(sbQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
